// File: rtl/act_feeder.sv
// rtl/act_feeder.sv - tile buffer and vector streamer feeding the systolic skew stage
//
// Buffers up to DEPTH activation vectors (N lanes of DATA_W bits), then on
// start streams them one per cycle, follows with N-1 all-zero flush vectors
// so the most-delayed skew lane drains, and finally pulses done.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   wr_valid   write request for one vector
//   wr_data    vector to store, lane i feeds skew row i
//   wr_ready   buffer accepts a vector this cycle (combinational)
//   start      single-cycle request to stream the loaded tile
//   clear      synchronous abort of buffer and FSM, beats start and writes
//   data_out   registered vector to the skew stage
//   out_valid  data_out carries a real tile vector
//   busy       data_out carries stream or flush output
//   done       one-cycle pulse after the flush completes
//   count      vectors currently loaded

module act_feeder #(
  parameter int N      = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  input  logic [DATA_W-1:0]            wr_data [N],
  output logic                         wr_ready,
  input  logic                         start,
  input  logic                         clear,
  output logic [DATA_W-1:0]            data_out [N],
  output logic                         out_valid,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = (N > 2) ? $clog2(N-1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t state, state_d;

  logic [DATA_W-1:0] mem [DEPTH][N];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [FW-1:0]     fc;

  logic              wr_fire, launch, rd_last, fc_last;

  logic [DATA_W-1:0] data_d [N];
  logic              out_valid_d, busy_d, done_d;

  assign wr_ready = (state == S_IDLE) && (count < CW'(DEPTH)) && !clear && rst;
  assign wr_fire  = wr_valid && wr_ready;

  // A write in the same cycle as start joins the tile, so an empty buffer
  // can still launch when that write lands.
  assign launch   = (state == S_IDLE) && start && !clear &&
                    ((count != '0) || wr_fire);

  assign rd_last  = ((CW'(rd_ptr) + CW'(1)) == count);
  assign fc_last  = (fc == FW'(N-2));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    if (clear) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (launch)  state_d = S_STREAM;
        S_STREAM: if (rd_last) state_d = S_FLUSH;
        S_FLUSH:  if (fc_last) state_d = S_DONE;
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Output logic: values the output registers take at the next edge
  always_comb begin
    for (int i = 0; i < N; i++) begin
      data_d[i] = '0;
    end
    out_valid_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    if (!clear) begin
      case (state)
        S_STREAM: begin
          for (int i = 0; i < N; i++) begin
            data_d[i] = mem[rd_ptr][i];
          end
          out_valid_d = 1'b1;
          busy_d      = 1'b1;
        end
        S_FLUSH: busy_d = 1'b1;
        S_DONE:  done_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        data_out[i] <= '0;
      end
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        data_out[i] <= data_d[i];
      end
      out_valid <= out_valid_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // Occupancy, pointers and flush counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fc     <= '0;
    end else if (clear) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fc     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (wr_fire) begin
            wr_ptr <= wr_ptr + PW'(1);
            count  <= count + CW'(1);
          end
          if (launch) begin
            rd_ptr <= '0;
          end
        end
        S_STREAM: begin
          rd_ptr <= rd_ptr + PW'(1);
          fc     <= '0;
        end
        S_FLUSH: begin
          fc <= fc + FW'(1);
        end
        S_DONE: begin
          count  <= '0;
          wr_ptr <= '0;
          rd_ptr <= '0;
        end
        default: ;
      endcase
    end
  end

  // Tile storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int i = 0; i < N; i++) begin
        mem[wr_ptr][i] <= wr_data[i];
      end
    end
  end

endmodule

// File: tb/tb_act_feeder.sv
// tb/tb_act_feeder.sv - directed vector-table bench for act_feeder

module tb_act_feeder;

  localparam int N      = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data [N];
  logic              wr_ready;
  logic              start;
  logic              clear;
  logic [DATA_W-1:0] data_out [N];
  logic              out_valid;
  logic              busy;
  logic              done;
  logic [3:0]        count;

  act_feeder #(.N(N), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .start    (start),
    .clear    (clear),
    .data_out (data_out),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done),
    .count    (count)
  );

  always #5 clk = ~clk;

  // dv < 0 means data_out must be all zero; otherwise lane i = 0x100*dv + i
  typedef struct {
    bit wv;
    int ws;
    bit st;
    bit cl;
    bit ov;
    bit bz;
    bit dn;
    int dv;
    int cnt;
    bit rdy;
  } row_t;

  row_t rows[$];
  int   nchk  = 0;
  int   nfail = 0;

  task automatic add(input bit wv, input int ws, input bit st, input bit cl,
                     input bit ov, input bit bz, input bit dn, input int dv,
                     input int cnt, input bit rdy);
    row_t r;
    r.wv = wv; r.ws = ws; r.st = st; r.cl = cl;
    r.ov = ov; r.bz = bz; r.dn = dn; r.dv = dv; r.cnt = cnt; r.rdy = rdy;
    rows.push_back(r);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input bit wv, input int ws, input bit st, input bit cl);
    wr_valid = wv;
    for (int i = 0; i < N; i++) wr_data[i] = 32'h100 * ws + i;
    start = st;
    clear = cl;
  endtask

  task automatic check_outs(input int idx, input bit ov, input bit bz, input bit dn,
                            input int dv, input int cnt, input bit rdy);
    chk("out_valid", idx, 32'(out_valid), 32'(ov));
    chk("busy",      idx, 32'(busy),      32'(bz));
    chk("done",      idx, 32'(done),      32'(dn));
    chk("count",     idx, 32'(count),     32'(cnt));
    chk("wr_ready",  idx, 32'(wr_ready),  32'(rdy));
    for (int i = 0; i < N; i++)
      chk("data_out", idx, data_out[i], (dv < 0) ? 32'h0 : 32'(32'h100 * dv + i));
  endtask

  // Inputs held through one rising edge, then released before sampling
  task automatic step(input bit wv, input int ws, input bit st, input bit cl);
    drive(wv, ws, st, cl);
    @(posedge clk);
    #1;
    drive(1'b0, 0, 1'b0, 1'b0);
    #1;
  endtask

  initial begin
    // Basic tile: 3 vectors, busy-time write/start ignored
    add(1, 0, 0, 0,  0, 0, 0, -1, 1, 1);
    add(1, 1, 0, 0,  0, 0, 0, -1, 2, 1);
    add(1, 2, 0, 0,  0, 0, 0, -1, 3, 1);
    add(0, 0, 1, 0,  0, 0, 0, -1, 3, 0);
    add(0, 0, 0, 0,  1, 1, 0,  0, 3, 0);
    add(1, 9, 1, 0,  1, 1, 0,  1, 3, 0);
    add(0, 0, 0, 0,  1, 1, 0,  2, 3, 0);
    add(0, 0, 1, 0,  0, 1, 0, -1, 3, 0);
    add(1, 9, 0, 0,  0, 1, 0, -1, 3, 0);
    add(0, 0, 0, 0,  0, 1, 0, -1, 3, 0);
    add(0, 0, 0, 0,  0, 0, 1, -1, 0, 1);
    add(0, 0, 0, 0,  0, 0, 0, -1, 0, 1);
    // start on empty buffer is ignored
    add(0, 0, 1, 0,  0, 0, 0, -1, 0, 1);
    for (int k = 0; k < 20; k++) add(0, 0, 0, 0,  0, 0, 0, -1, 0, 1);
    // write+start with count=2 streams 3 vectors
    add(1, 3, 0, 0,  0, 0, 0, -1, 1, 1);
    add(1, 4, 0, 0,  0, 0, 0, -1, 2, 1);
    add(1, 5, 1, 0,  0, 0, 0, -1, 3, 0);
    add(0, 0, 0, 0,  1, 1, 0,  3, 3, 0);
    add(0, 0, 0, 0,  1, 1, 0,  4, 3, 0);
    add(0, 0, 0, 0,  1, 1, 0,  5, 3, 0);
    for (int k = 0; k < N-1; k++) add(0, 0, 0, 0,  0, 1, 0, -1, 3, 0);
    add(0, 0, 0, 0,  0, 0, 1, -1, 0, 1);
    add(0, 0, 0, 0,  0, 0, 0, -1, 0, 1);
    // full buffer: 8 stored, 9th refused, start still allowed
    for (int k = 0; k < DEPTH; k++)
      add(1, 8'h10 + k, 0, 0,  0, 0, 0, -1, k + 1, (k < DEPTH-1) ? 1'b1 : 1'b0);
    add(1, 8'h1F, 0, 0,  0, 0, 0, -1, DEPTH, 0);
    add(0, 0, 1, 0,  0, 0, 0, -1, DEPTH, 0);
    for (int k = 0; k < DEPTH; k++) add(0, 0, 0, 0,  1, 1, 0, 8'h10 + k, DEPTH, 0);
    for (int k = 0; k < N-1; k++) add(0, 0, 0, 0,  0, 1, 0, -1, DEPTH, 0);
    add(0, 0, 0, 0,  0, 0, 1, -1, 0, 1);
    add(0, 0, 0, 0,  0, 0, 0, -1, 0, 1);
    // clear at second STREAM cycle: no done afterwards
    add(1, 8'h20, 0, 0,  0, 0, 0, -1, 1, 1);
    add(1, 8'h21, 0, 0,  0, 0, 0, -1, 2, 1);
    add(1, 8'h22, 0, 0,  0, 0, 0, -1, 3, 1);
    add(0, 0, 1, 0,  0, 0, 0, -1, 3, 0);
    add(0, 0, 0, 0,  1, 1, 0, 8'h20, 3, 0);
    add(0, 0, 0, 1,  0, 0, 0, -1, 0, 1);
    for (int k = 0; k < 6; k++) add(0, 0, 0, 0,  0, 0, 0, -1, 0, 1);
    // clear beats a write in the same cycle
    add(1, 8'h40, 0, 1,  0, 0, 0, -1, 0, 1);
    add(0, 0, 0, 0,  0, 0, 0, -1, 0, 1);

    // Reset with random inputs
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      wr_valid = 1'($urandom_range(0, 1));
      start    = 1'($urandom_range(0, 1));
      clear    = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) wr_data[i] = $urandom();
      @(posedge clk);
      #1;
      check_outs(-1 - c, 0, 0, 0, -1, 0, 0);
    end
    @(negedge clk);
    drive(1'b0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("wr_ready_after_reset", 0, 32'(wr_ready), 32'd1);

    foreach (rows[k]) begin
      step(rows[k].wv, rows[k].ws, rows[k].st, rows[k].cl);
      check_outs(k, rows[k].ov, rows[k].bz, rows[k].dn, rows[k].dv, rows[k].cnt, rows[k].rdy);
    end

    // Asynchronous reset in the middle of FLUSH
    step(1, 8'h30, 0, 0); check_outs(1000, 0, 0, 0, -1,    1, 1);
    step(0, 0,     1, 0); check_outs(1001, 0, 0, 0, -1,    1, 0);
    step(0, 0,     0, 0); check_outs(1002, 1, 1, 0, 8'h30, 1, 0);
    step(0, 0,     0, 0); check_outs(1003, 0, 1, 0, -1,    1, 0);
    rst = 1'b0;
    #1;
    check_outs(1004, 0, 0, 0, -1, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 0, 0);
      check_outs(1005 + k, 0, 0, 0, -1, 0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/act_feeder.md
Name: act_feeder

Overview:
- Upstream neighbour of the systolic skew triangle.
- Buffers a tile of activation vectors (one DATA_W word per array row), then streams one vector per cycle into the skew stage's unpacked data_in array.
- After the tile, drives N-1 all-zero flush vectors so the most-delayed lane drains, then pulses done.
- Single clock domain; no backpressure, because the skew stage and the array cannot stall.

Parameters:
- N, 4, array dimension / lanes per vector; must equal the skew stage's MAX_DELAY.
- DATA_W, 32, bits per lane word.
- DEPTH, 8, maximum vectors per tile held in the internal buffer (N ≥ 2, DEPTH ≥ 1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_valid  in  1  write request for one vector.
- wr_data  in  [DATA_W-1:0] x N (unpacked)  vector to store; lane i feeds skew row i.
- wr_ready  out  1  buffer accepts a vector this cycle.
- start  in  1  single-cycle request to stream the loaded tile.
- clear  in  1  synchronous abort/flush of the buffer and FSM.
- data_out  out  [DATA_W-1:0] x N (unpacked)  registered vector to the skew stage.
- out_valid  out  1  data_out carries a real tile vector.
- busy  out  1  FSM in STREAM or FLUSH.
- done  out  1  one-cycle pulse after the flush completes.
- count  out  clog2(DEPTH+1)  vectors currently loaded.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, count=0, wr_ptr=rd_ptr=0, data_out all 0, out_valid=0, busy=0, done=0. Buffer storage is not reset.
- While rst is low, wr_ready=0. Reset mid-stream abandons the tile; no done is produced.
- States: IDLE, STREAM, FLUSH, DONE. All outputs except wr_ready are registered.
- wr_ready = (state==IDLE) && (count<DEPTH) && !clear && rst.
- Write acceptance: wr_valid && wr_ready stores wr_data at buf[wr_ptr], then wr_ptr++ and count++. Writes are never accepted outside IDLE.
- IDLE -> STREAM: start=1 and (count>0, or a write accepted the same cycle). A write and start in the same cycle include that vector in the tile; rd_ptr=0.
- start with effective count 0 is ignored: no output, no done.
- start outside IDLE is ignored.
- STREAM: each cycle, data_out <= buf[rd_ptr], out_valid <= 1, rd_ptr++. After count vectors, go to FLUSH with flush counter fc=0.
  - Latency: start sampled at edge e → first vector on data_out after edge e+1. Vectors appear on consecutive cycles.
- FLUSH: data_out <= all zeros, out_valid <= 0, for exactly N-1 cycles (fc counts 0..N-2). Then go to DONE.
- DONE: done=1 for one cycle, busy=0, data_out=0. count, wr_ptr and rd_ptr clear to 0. Next state is IDLE.
- busy=1 on exactly the cycles data_out carries STREAM or FLUSH output.
- clear=1, any state: next edge gives state=IDLE, count=0, pointers 0, data_out=0, out_valid=0, done=0. clear has priority over start and writes in the same cycle.
- Pointer widths are clog2(DEPTH) and never wrap within a tile, because count ≤ DEPTH.
- A full buffer (count==DEPTH) deasserts wr_ready but still allows start.

Test Plan:
- Reset: hold rst=0 for 3 cycles with random inputs → data_out=0, out_valid=0, busy=0, done=0, count=0, wr_ready=0. Release rst → wr_ready=1.
- Basic tile (N=4): write 3 vectors, lane i of vector v = 0x100*v+i, then pulse start at cycle t.
  - Cycles t+1..t+3: out_valid=1 with vectors 0,1,2 exact.
  - Cycles t+4..t+6: data_out=0, out_valid=0, busy=1.
  - Cycle t+7: done=1, busy=0. Cycle t+8: count=0, wr_ready=1.
- Full buffer: write 8 vectors → count=8, wr_ready=0. A 9th wr_valid is not stored. start streams exactly 8 vectors, then 3 flush cycles, then done.
- Ignored requests:
  - start with count=0 → no out_valid and no done over 20 cycles.
  - During busy, wr_valid and start are not accepted; wr_ready=0 and the stream is unchanged.
- Simultaneous write+start in IDLE with count=2 → 3 vectors streamed, the third being the write-cycle data.
- Abort:
  - clear at the second STREAM cycle → next cycle IDLE, out_valid=0, data_out=0, count=0; done is never pulsed.
  - Repeat with rst pulsed low mid-FLUSH → outputs go to 0 asynchronously; no done.
